jt12_ch_acc: RTL and testbench

- Consumer end of the operator output stream.
- Takes the signed 14-bit operator result, one slot per clk_en, in slot order S1, S3, S2, S4 with num_ch channels per group.
- Keeps only carrier operators, as selected by the channel algorithm, and sums them per channel.
- Pans each channel sum into left/right frame totals.
- Once per 24-slot frame (num_ch=6): saturates the totals to 16-bit stereo samples and issues a sample strobe.

---
 rtl/jt12_ch_acc_pkg.sv | 34 +++
 rtl/jt12_acc_dly.sv | 32 +++
 rtl/jt12_ch_acc.sv | 128 ++++++++++++
 tb/tb_jt12_ch_acc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jt12_ch_acc_pkg.sv
// Shared constants for the channel accumulator: carrier masks, slot order and
// 16-bit output saturation.
package jt12_ch_acc_pkg;

    // Slot order within a frame; the value also selects the bit in a carrier mask.
    typedef enum logic [1:0] {
        SLOT_S1 = 2'd0,
        SLOT_S3 = 2'd1,
        SLOT_S2 = 2'd2,
        SLOT_S4 = 2'd3
    } slot_t;

    // One nibble per algorithm (alg 7 in the top nibble), bits {S4, S2, S3, S1}.
    localparam logic [31:0] CARRIER_MASK = {
        4'b1111, 4'b1110, 4'b1110, 4'b1100,
        4'b1000, 4'b1000, 4'b1000, 4'b1000
    };

    localparam logic signed [18:0] SAT16_MAX = 19'sd32767;
    localparam logic signed [18:0] SAT16_MIN = -19'sd32768;

    function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
        logic signed [15:0] y;
        if (x > SAT16_MAX) begin
            y = 16'sh7fff;
        end else if (x < SAT16_MIN) begin
            y = -16'sh8000;
        end else begin
            y = x[15:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/jt12_acc_dly.sv
// Enable-gated shift register with asynchronous clear; holds one partial sum
// per channel so each channel meets its own value again one group later.
module jt12_acc_dly #(
    parameter int W      = 16,
    parameter int STAGES = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_mem [STAGES];

    // Shift one stage per slot; clear every stage on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (i_clk_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < STAGES; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[STAGES-1];

endmodule

// File: rtl/jt12_ch_acc.sv
// Channel accumulator: sums carrier operators per channel, pans the sums into
// frame totals and emits saturated stereo samples once per frame.
module jt12_ch_acc
    import jt12_ch_acc_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic signed [13:0] op_result,
    input  logic        [2:0]  alg,
    input  logic        [1:0]  pan,
    input  logic               s1_enters,
    input  logic               s2_enters,
    input  logic               s3_enters,
    input  logic               s4_enters,
    input  logic               zero,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               sample
);

    slot_t              w_slot;
    logic               w_slot_vld;
    logic        [3:0]  w_mask;
    logic               w_carrier;
    logic signed [15:0] w_v;
    logic signed [15:0] w_dly_out;
    logic signed [15:0] w_dly_in;
    logic signed [15:0] w_ch_sum;
    logic signed [18:0] w_sum_ext;
    logic               w_is_s4;

    logic signed [18:0] r_tl;
    logic signed [18:0] r_tr;
    logic signed [15:0] r_left;
    logic signed [15:0] r_right;
    logic               r_sample;

    // Slot decode with priority S1 > S3 > S2 > S4.
    always_comb begin
        w_slot     = SLOT_S1;
        w_slot_vld = 1'b1;
        if (s1_enters) begin
            w_slot = SLOT_S1;
        end else if (s3_enters) begin
            w_slot = SLOT_S3;
        end else if (s2_enters) begin
            w_slot = SLOT_S2;
        end else if (s4_enters) begin
            w_slot = SLOT_S4;
        end else begin
            w_slot_vld = 1'b0;
        end
    end

    assign w_mask    = CARRIER_MASK[{alg, 2'b00} +: 4];
    assign w_carrier = w_slot_vld & w_mask[w_slot];
    assign w_v       = w_carrier ? {{2{op_result[13]}}, op_result} : 16'sd0;
    assign w_ch_sum  = w_dly_out + w_v;
    assign w_sum_ext = {{3{w_ch_sum[15]}}, w_ch_sum};
    assign w_is_s4   = w_slot_vld && (w_slot == SLOT_S4);

    // S1 restarts the channel sum; other slots (or none) extend the delayed one.
    always_comb begin
        w_dly_in = w_ch_sum;
        if (w_slot_vld) begin
            case (w_slot)
                SLOT_S1: w_dly_in = w_v;
                SLOT_S3: w_dly_in = w_ch_sum;
                SLOT_S2: w_dly_in = w_ch_sum;
                SLOT_S4: w_dly_in = w_ch_sum;
                default: w_dly_in = w_ch_sum;
            endcase
        end else begin
            w_dly_in = w_ch_sum;
        end
    end

    jt12_acc_dly #(
        .W      (16),
        .STAGES (num_ch)
    ) u_dly (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .i_din    (w_dly_in),
        .o_dout   (w_dly_out)
    );

    // Frame totals and output samples; the frame clear takes precedence over S4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tl    <= 19'sd0;
            r_tr    <= 19'sd0;
            r_left  <= 16'sd0;
            r_right <= 16'sd0;
        end else if (clk_en) begin
            if (zero) begin
                r_left  <= sat16(r_tl);
                r_right <= sat16(r_tr);
                r_tl    <= 19'sd0;
                r_tr    <= 19'sd0;
            end else if (w_is_s4) begin
                r_tl <= r_tl + (pan[1] ? w_sum_ext : 19'sd0);
                r_tr <= r_tr + (pan[0] ? w_sum_ext : 19'sd0);
            end else begin
                r_tl <= r_tl;
                r_tr <= r_tr;
            end
        end
    end

    // One-clock sample strobe aligned with the output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 1'b0;
        end else begin
            r_sample <= clk_en & zero;
        end
    end

    assign left   = r_left;
    assign right  = r_right;
    assign sample = r_sample;

endmodule

// File: tb/tb_jt12_ch_acc.sv
// Directed bench for jt12_ch_acc: stimulus pushes expected frame samples into a
// queue, a monitor pops and compares on every sample strobe.
module tb_jt12_ch_acc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_en = 1'b0;
    logic signed [13:0] op_result = 14'sd0;
    logic        [2:0]  alg = 3'd0;
    logic        [1:0]  pan = 2'd0;
    logic               s1_enters = 1'b0;
    logic               s2_enters = 1'b0;
    logic               s3_enters = 1'b0;
    logic               s4_enters = 1'b0;
    logic               zero = 1'b0;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               sample;

    int                 n_chk = 0;
    int                 n_fail = 0;
    logic [31:0]        sb_q [$];
    logic [31:0]        exp_pend = 32'd0;
    logic signed [13:0] ops [24];
    logic               prev_sample = 1'b0;

    jt12_ch_acc #(.num_ch(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .op_result (op_result),
        .alg       (alg),
        .pan       (pan),
        .s1_enters (s1_enters),
        .s2_enters (s2_enters),
        .s3_enters (s3_enters),
        .s4_enters (s4_enters),
        .zero      (zero),
        .left      (left),
        .right     (right),
        .sample    (sample)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_ops();
        for (int i = 0; i < 24; i++) ops[i] = 14'sd0;
    endtask

    task automatic set_ch(input int ch, input logic signed [13:0] v1, input logic signed [13:0] v3,
                          input logic signed [13:0] v2, input logic signed [13:0] v4);
        ops[ch]      = v1;
        ops[6 + ch]  = v3;
        ops[12 + ch] = v2;
        ops[18 + ch] = v4;
    endtask

    task automatic fill_ops(input logic signed [13:0] v);
        for (int i = 0; i < 24; i++) ops[i] = v;
    endtask

    // Drive slots 0..last; gap idle (clk_en=0, zero=1) cycles precede each slot.
    task automatic run_frame(input logic [2:0] a, input logic [1:0] p, input int last, input int gap,
                             input logic signed [15:0] el, input logic signed [15:0] er);
        for (int k = 0; k <= last; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                clk_en    = 1'b0;
                zero      = 1'b1;
                op_result = 14'($urandom);
                alg       = 3'($urandom);
                pan       = 2'($urandom);
                {s1_enters, s3_enters, s2_enters, s4_enters} = 4'($urandom);
            end
            @(negedge clk);
            clk_en    = 1'b1;
            op_result = ops[k];
            alg       = a;
            pan       = (k / 6 == 3) ? p : 2'($urandom);
            s1_enters = (k / 6 == 0);
            s3_enters = (k / 6 == 1);
            s2_enters = (k / 6 == 2);
            s4_enters = (k / 6 == 3);
            zero      = (k == 0);
            if (k == 0) sb_q.push_back(exp_pend);
        end
        exp_pend = {el, er};
    endtask

    task automatic go_idle();
        @(negedge clk);
        clk_en = 1'b0;
        zero   = 1'b0;
        {s1_enters, s3_enters, s2_enters, s4_enters} = 4'b0000;
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (sample) begin
                if (prev_sample) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sample_width actual=2 clk required=1 clk");
                end else if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_sample actual=pulse required=none");
                end else begin
                    e = sb_q.pop_front();
                    chk("left", {16'h0000, left}, {16'h0000, e[31:16]});
                    chk("right", {16'h0000, right}, {16'h0000, e[15:0]});
                end
            end
            prev_sample = sample;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_left", {16'h0000, left}, 32'd0);
        chk("rst_right", {16'h0000, right}, 32'd0);
        chk("rst_sample", {31'd0, sample}, 32'd0);
        rst      = 1'b0;
        exp_pend = 32'd0;

        clear_ops(); set_ch(1 - 1, 14'sd100, 14'sd100, 14'sd100, 14'sd100);
        run_frame(3'd7, 2'b11, 23, 0, 16'sd400, 16'sd400);
        clear_ops(); set_ch(2, 14'sd1000, 14'sd1000, 14'sd1000, -14'sd50);
        run_frame(3'd0, 2'b11, 23, 0, -16'sd50, -16'sd50);
        clear_ops(); set_ch(1, 14'sd777, 14'sd777, 14'sd300, 14'sd200);
        run_frame(3'd4, 2'b10, 23, 0, 16'sd500, 16'sd0);
        run_frame(3'd4, 2'b01, 23, 0, 16'sd0, 16'sd500);
        fill_ops(14'sd8191);
        run_frame(3'd7, 2'b11, 23, 0, 16'sd32767, 16'sd32767);
        fill_ops(-14'sd8192);
        run_frame(3'd7, 2'b11, 23, 0, -16'sd32768, -16'sd32768);

        // Partial frame up to channel 0 S2, then asynchronous reset mid-cycle.
        clear_ops(); set_ch(0, 14'sd100, 14'sd100, 14'sd100, 14'sd100);
        run_frame(3'd7, 2'b11, 12, 0, 16'sd400, 16'sd400);
        go_idle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_left", {16'h0000, left}, 32'd0);
        chk("async_rst_right", {16'h0000, right}, 32'd0);
        chk("async_rst_sample", {31'd0, sample}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        exp_pend = 32'd0;

        fill_ops(14'sd0);
        run_frame(3'd7, 2'b11, 23, 0, 16'sd0, 16'sd0);
        clear_ops(); set_ch(0, 14'sd100, 14'sd100, 14'sd100, 14'sd100);
        run_frame(3'd7, 2'b11, 23, 2, 16'sd400, 16'sd400);
        fill_ops(14'sd0);
        run_frame(3'd7, 2'b11, 23, 2, 16'sd0, 16'sd0);
        run_frame(3'd7, 2'b11, 0, 0, 16'sd0, 16'sd0);
        go_idle();

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
